uart_cmd_wrapper: RTL

//  Serial front end of the scope's command path: a UART RX/TX pair plus command framing.
//  RX assembles three bytes into the 24-bit cmd word and raises cmd_rdy.
//  The command/config FSM consumes cmd, clears it with clr_cmd_rdy and returns one response

---
 rtl/uart_cmd_wrapper_if.sv | 15 +
 rtl/uart_cmd_wrapper.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_wrapper_if.sv
// Command-side handshake between the UART front end and the command/config FSM.
// The command FSM takes the master modport and the UART block takes the slave modport.
interface uart_cmd_wrapper_if;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp_data;
    logic        resp_sent;

    modport master (input  cmd, cmd_rdy, resp_sent,
                    output clr_cmd_rdy, send_resp, resp_data);
    modport slave  (output cmd, cmd_rdy, resp_sent,
                    input  clr_cmd_rdy, send_resp, resp_data);
endinterface

// File: rtl/uart_cmd_wrapper.sv
// UART RX/TX pair for the scope command path. RX assembles 3-byte commands and
// TX serialises one response byte per send_resp request.
module uart_cmd_wrapper #(
    parameter int BAUD_DIV = 2604
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RX,
    output logic TX,
    uart_cmd_wrapper_if.slave bus
);
    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    uart_state_t   rx_state, tx_state;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] rx_cnt, tx_cnt;
    logic [2:0]    rx_bit, tx_bit;
    logic [7:0]    rx_shift, tx_shift;
    logic          byte_done;
    logic [1:0]    byte_cnt;
    logic [23:0]   cmd_q;
    logic          cmd_rdy_q;
    logic          resp_sent_q;

    // NOTE: synchroniser flops reset to the idle-high level so that releasing
    // reset never looks like a falling edge on the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_sync) rx_state <= S_START;
                end
                S_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        // A line already back high at mid start bit was a glitch.
                        rx_state <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BAUD_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == BAUD_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // A byte is delivered on the stop sample itself so cmd_rdy can rise on the next cycle.
    assign byte_done = (rx_state == S_STOP) && (rx_cnt == BAUD_LAST) && rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            byte_cnt  <= '0;
        end else if (bus.clr_cmd_rdy) begin
            // NOTE: the clear has priority over a coinciding byte, which is dropped.
            cmd_rdy_q <= 1'b0;
            byte_cnt  <= '0;
        end else if (byte_done && !cmd_rdy_q) begin
            case (byte_cnt)
                2'd0:    cmd_q[23:16] <= rx_shift;
                2'd1:    cmd_q[15:8]  <= rx_shift;
                default: cmd_q[7:0]   <= rx_shift;
            endcase
            if (byte_cnt == 2'd2) begin
                cmd_rdy_q <= 1'b1;
                byte_cnt  <= '0;
            end else begin
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= S_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            TX          <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            resp_sent_q <= 1'b0;
            case (tx_state)
                S_IDLE: begin
                    tx_cnt <= '0;
                    if (bus.send_resp) begin
                        tx_shift <= bus.resp_data;
                        TX       <= 1'b0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == BAUD_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        TX       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == BAUD_LAST) begin
                        tx_cnt <= '0;
                        tx_bit <= tx_bit + 3'd1;
                        if (tx_bit == 3'd7) begin
                            TX       <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            TX       <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == BAUD_LAST) begin
                        tx_cnt      <= '0;
                        resp_sent_q <= 1'b1;
                        tx_state    <= S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.cmd       = cmd_q;
    assign bus.cmd_rdy   = cmd_rdy_q;
    assign bus.resp_sent = resp_sent_q;
endmodule
